// File: rtl/pipe_mem_stage_if.sv
// EX->MEM->WB handshake, payload and data SRAM response bundle for pipe_mem_stage.
interface pipe_mem_stage_if;
  logic        from_valid;
  logic        to_allowin;
  logic        from_allowin;
  logic        to_valid;
  logic        flush_WB;
  logic [31:0] from_pc;
  logic [4:0]  load_op_EX;
  logic [31:0] alu_result_EX;
  logic        res_from_mem_EX;
  logic        mem_req_EX;
  logic        rf_we_EX;
  logic [4:0]  rf_waddr_EX;
  logic        ex_EX;
  logic [5:0]  ecode_EX;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ex;
  logic [5:0]  ecode;
  logic [31:0] PC;
  logic        load_pending;
  logic        discard_busy;

  modport slave (
    input  from_valid, from_allowin, flush_WB, from_pc, load_op_EX, alu_result_EX,
           res_from_mem_EX, mem_req_EX, rf_we_EX, rf_waddr_EX, ex_EX, ecode_EX,
           data_sram_data_ok, data_sram_rdata,
    output to_allowin, to_valid, rf_we, rf_waddr, rf_wdata, ex, ecode, PC,
           load_pending, discard_busy
  );

  modport master (
    output from_valid, from_allowin, flush_WB, from_pc, load_op_EX, alu_result_EX,
           res_from_mem_EX, mem_req_EX, rf_we_EX, rf_waddr_EX, ex_EX, ecode_EX,
           data_sram_data_ok, data_sram_rdata,
    input  to_allowin, to_valid, rf_we, rf_waddr, rf_wdata, ex, ecode, PC,
           load_pending, discard_busy
  );
endinterface

// File: rtl/pipe_mem_stage.sv
// MEM stage with variable-latency data SRAM response, WB-stall buffering and killed-response discard.
// Optional stall counter output enabled by defining MEM_STALL_CNT_EN.
module pipe_mem_stage #(
  parameter int CNT_W = 2
`ifdef MEM_STALL_CNT_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  pipe_mem_stage_if.slave   bus
`ifdef MEM_STALL_CNT_EN
  , output logic [PERF_W-1:0] stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MAX_DISCARD = '1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  load_op;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        ex;
    logic [5:0]  ecode;
  } mem_ctx_t;

  mem_ctx_t          ctx;
  logic              valid;
  logic              resp_pending;
  logic              buf_valid;
  logic [31:0]       buf_data;
  logic [CNT_W-1:0]  discard_cnt;

  logic              data_ok_eff;
  logic              ready_go;
  logic              fire;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [31:0]       rd;
  logic [7:0]        rd_b;
  logic [15:0]       rd_h;
  logic [31:0]       ld_val;

  assign data_ok_eff = bus.data_sram_data_ok & (discard_cnt == '0);
  assign ready_go    = ~resp_pending | buf_valid | data_ok_eff;
  assign bus.to_valid   = valid & ready_go & ~bus.flush_WB;
  assign bus.to_allowin = (~valid | (ready_go & bus.from_allowin)) & (discard_cnt != MAX_DISCARD);
  assign fire = bus.from_valid & bus.to_allowin;

  // A killed load whose response is still in flight must swallow one future beat.
  assign cnt_inc = bus.flush_WB & valid & resp_pending & ~buf_valid & ~data_ok_eff;
  assign cnt_dec = bus.data_sram_data_ok & (discard_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid        <= 1'b0;
      resp_pending <= 1'b0;
      buf_valid    <= 1'b0;
      buf_data     <= '0;
      ctx          <= '0;
    end else begin
      if (fire) begin
        ctx.pc           <= bus.from_pc;
        ctx.load_op      <= bus.load_op_EX;
        ctx.alu_result   <= bus.alu_result_EX;
        ctx.res_from_mem <= bus.res_from_mem_EX;
        ctx.rf_we        <= bus.rf_we_EX;
        ctx.rf_waddr     <= bus.rf_waddr_EX;
        ctx.ex           <= bus.ex_EX;
        ctx.ecode        <= bus.ecode_EX;
      end
      if (bus.flush_WB) begin
        valid        <= 1'b0;
        resp_pending <= 1'b0;
        buf_valid    <= 1'b0;
      end else if (bus.to_allowin) begin
        valid        <= bus.from_valid;
        resp_pending <= fire & bus.mem_req_EX;
        buf_valid    <= 1'b0;
      end else if (valid & resp_pending & data_ok_eff & ~bus.from_allowin) begin
        buf_valid <= 1'b1;
        buf_data  <= bus.data_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   discard_cnt <= '0;
    else if (cnt_inc & ~cnt_dec) discard_cnt <= discard_cnt + 1'b1;
    else if (cnt_dec & ~cnt_inc) discard_cnt <= discard_cnt - 1'b1;
  end

  always_comb begin
    rd = buf_valid ? buf_data : bus.data_sram_rdata;
    case (ctx.alu_result[1:0])
      2'd0:    rd_b = rd[7:0];
      2'd1:    rd_b = rd[15:8];
      2'd2:    rd_b = rd[23:16];
      default: rd_b = rd[31:24];
    endcase
    rd_h = ctx.alu_result[1] ? rd[31:16] : rd[15:0];
    // load_op is one-hot {ld.b, ld.bu, ld.h, ld.hu, ld.w}
    ld_val = rd;
    if (ctx.load_op[4])      ld_val = {{24{rd_b[7]}}, rd_b};
    else if (ctx.load_op[3]) ld_val = {24'd0, rd_b};
    else if (ctx.load_op[2]) ld_val = {{16{rd_h[15]}}, rd_h};
    else if (ctx.load_op[1]) ld_val = {16'd0, rd_h};
  end

  assign bus.rf_wdata     = ctx.res_from_mem ? ld_val : ctx.alu_result;
  assign bus.rf_we        = ctx.rf_we;
  assign bus.rf_waddr     = ctx.rf_waddr;
  assign bus.ex           = ctx.ex;
  assign bus.ecode        = ctx.ecode;
  assign bus.PC           = ctx.pc;
  assign bus.load_pending = valid & ctx.res_from_mem & resp_pending & ~buf_valid & ~data_ok_eff;
  assign bus.discard_busy = (discard_cnt != '0);

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                 stall_cnt <= '0;
    else if (valid & ~ready_go) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Scoreboard bench for pipe_mem_stage: expected WB beats queued at issue, compared on hand-off.
module tb_pipe_mem_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_mem_stage_if bus();

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
  pipe_mem_stage #(.CNT_W(2), .PERF_W(32)) dut (.clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
`else
  pipe_mem_stage #(.CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  localparam logic [4:0] OP_B = 5'b10000, OP_BU = 5'b01000, OP_H = 5'b00100,
                         OP_HU = 5'b00010, OP_W = 5'b00001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  waddr;
    logic        ex;
    logic [5:0]  ecode;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.to_valid && bus.from_allowin) begin
      if (sb.size() == 0) chk("unexp_out", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("wb_out", {bus.PC, bus.rf_wdata, bus.rf_we, bus.rf_waddr, bus.ex, bus.ecode}, mon_e);
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] alu,
                       input logic res_mem, input logic mem_req, input logic [4:0] waddr,
                       input logic exf, input logic [5:0] ec, input logic push,
                       input logic [31:0] wdata);
    int n;
    exp_t e;
    bus.from_valid      = 1'b1;
    bus.from_pc         = pc;
    bus.load_op_EX      = op;
    bus.alu_result_EX   = alu;
    bus.res_from_mem_EX = res_mem;
    bus.mem_req_EX      = mem_req;
    bus.rf_we_EX        = 1'b1;
    bus.rf_waddr_EX     = waddr;
    bus.ex_EX           = exf;
    bus.ecode_EX        = ec;
    #1;
    n = 0;
    while (!bus.to_allowin && n < 20) begin step(); n++; end
    if (n == 20) chk("issue_timeout", 0, 1);
    if (push) begin
      e = '{pc: pc, wdata: wdata, we: 1'b1, waddr: waddr, ex: exf, ecode: ec};
      sb.push_back(e);
    end
    step();
    bus.from_valid = 1'b0;
  endtask

  task automatic pulse_ok(input logic [31:0] d);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = d;
    step();
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] wdata);
    issue(pc, op, addr, 1'b1, 1'b1, 5'd3, 1'b0, 6'd0, 1'b1, wdata);
    pulse_ok(rdata);
  endtask

  initial begin
    reset = 1'b1;
    bus.from_valid = 0; bus.from_allowin = 1; bus.flush_WB = 0;
    bus.from_pc = 0; bus.load_op_EX = 0; bus.alu_result_EX = 0; bus.res_from_mem_EX = 0;
    bus.mem_req_EX = 0; bus.rf_we_EX = 0; bus.rf_waddr_EX = 0; bus.ex_EX = 0; bus.ecode_EX = 0;
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0;
    step(); step();
    chk("rst_out", {bus.to_valid, bus.rf_we, bus.rf_waddr, bus.ex, bus.ecode, bus.PC, bus.rf_wdata,
                    bus.load_pending, bus.discard_busy}, 0);
    chk("rst_allowin", bus.to_allowin, 1);
    reset = 1'b0;
    step();

    // ld.w with 3-cycle response latency
    issue(32'h100, OP_W, 32'h1000, 1, 1, 5'd4, 0, 0, 1, 32'h8899AABB);
    for (int i = 0; i < 3; i++) begin
      chk("ldw_pend", {bus.load_pending, bus.to_valid}, 2'b10);
      step();
    end
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h8899AABB;
    #1;
    chk("ldw_ok", {bus.to_valid, bus.load_pending}, 2'b10);
    step();
    bus.data_sram_data_ok = 1'b0;

    // extension cases
    do_load(32'h200, OP_B,  32'h2003, 32'h80112233, 32'hFFFFFF80);
    do_load(32'h204, OP_HU, 32'h2002, 32'h80112233, 32'h00008011);
    do_load(32'h208, OP_H,  32'h2000, 32'h80112233, 32'h00002233);
    do_load(32'h20C, OP_BU, 32'h2001, 32'h80112233, 32'h00000022);
    do_load(32'h210, OP_H,  32'h2002, 32'h80112233, 32'hFFFF8011);

    // response captured while WB stalls
    issue(32'h300, OP_W, 32'h3000, 1, 1, 5'd7, 0, 0, 1, 32'h11223344);
    bus.from_allowin = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h11223344;
    #1;
    chk("buf_ok", bus.to_valid, 1);
    step();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("buf_hold", {bus.to_valid, bus.to_allowin, bus.rf_wdata}, {2'b10, 32'h11223344});
      step();
    end
    bus.from_allowin = 1'b1;
    step();

    // flush a pending load; its late response must be dropped
    issue(32'h400, OP_W, 32'h4000, 1, 1, 5'd8, 0, 0, 0, 0);
    bus.flush_WB = 1'b1;
    #1;
    chk("flush_tv", bus.to_valid, 0);
    step();
    bus.flush_WB = 1'b0;
    chk("disc_busy1", bus.discard_busy, 1);
    issue(32'h404, OP_W, 32'h4004, 1, 1, 5'd9, 0, 0, 1, 32'h5555AAAA);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0000DEAD;
    #1;
    chk("disc_drop", {bus.to_valid, bus.load_pending}, 2'b01);
    step();
    chk("disc_busy0", bus.discard_busy, 0);
    pulse_ok(32'h5555AAAA);

    // saturate the discard counter
    for (int i = 0; i < 3; i++) begin
      issue(32'h500 + 32'(i * 4), OP_W, 32'h5000, 1, 1, 5'd10, 0, 0, 0, 0);
      bus.flush_WB = 1'b1;
      step();
      bus.flush_WB = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      chk("sat_allowin", {bus.to_allowin, bus.discard_busy}, 2'b01);
      step();
    end
    pulse_ok(32'h0);
    chk("sat_release", bus.to_allowin, 1);
    issue(32'h510, OP_W, 32'h5010, 1, 1, 5'd11, 0, 0, 0, 0);
    bus.flush_WB = 1'b1;
    bus.data_sram_data_ok = 1'b1;
    step();
    bus.flush_WB = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    chk("inc_dec_cnt", {bus.to_allowin, bus.discard_busy}, 2'b11);
    pulse_ok(32'h0);
    chk("drain1", bus.discard_busy, 1);
    pulse_ok(32'h0);
    chk("drain0", bus.discard_busy, 0);

    // ALU op, one-cycle pass-through
    issue(32'h600, 5'd0, 32'h1234, 0, 0, 5'd12, 1, 6'h0b, 1, 32'h1234);
    chk("alu_tv", bus.to_valid, 1);
    step();

    // reset while waiting with outstanding discards
    issue(32'h700, OP_W, 32'h7000, 1, 1, 5'd5, 0, 0, 0, 0);
    bus.flush_WB = 1'b1;
    step();
    bus.flush_WB = 1'b0;
    issue(32'h704, OP_B, 32'h7001, 1, 1, 5'd6, 1, 6'h3, 0, 0);
    reset = 1'b1;
    step();
    chk("midrst_out", {bus.to_valid, bus.rf_we, bus.rf_waddr, bus.ex, bus.ecode, bus.PC, bus.rf_wdata,
                       bus.load_pending, bus.discard_busy}, 0);
    reset = 1'b0;
    step();
    do_load(32'h800, OP_BU, 32'h8001, 32'h80112233, 32'h00000022);

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
- Parametrised next-generation MEM stage for the 5-stage LoongArch pipeline, sitting between EX and WB.
- Unlike the fixed-latency stage, the data SRAM response arrives a variable number of cycles later via data_sram_data_ok. The stage waits for the response and buffers it while WB stalls.
- Responses belonging to instructions killed by a WB flush are silently discarded using an in-order discard counter.
- Load data is aligned and sign/zero-extended here before being forwarded to WB.

Parameters:
- CNT_W, 2, width of the discard counter; MAX_DISCARD = 2**CNT_W-1 outstanding killed responses.
- PERF_W, 32, width of the stall counter (only with the optional feature).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- from_valid  in  1  EX has a valid instruction to hand over
- to_allowin  out  1  MEM can accept from EX
- from_allowin  in  1  WB can accept from MEM
- to_valid  out  1  MEM hands a completed instruction to WB
- flush_WB  in  1  exception/ertn flush from WB
- from_pc  in  32  EX PC
- load_op_EX  in  5  one-hot {ld.b, ld.bu, ld.h, ld.hu, ld.w}
- alu_result_EX  in  32  address or ALU result
- res_from_mem_EX  in  1  write-back value comes from memory
- mem_req_EX  in  1  EX issued a data SRAM request (load or store) that was accepted
- rf_we_EX  in  1  register write enable from EX
- rf_waddr_EX  in  5  destination register from EX
- ex_EX  in  1  exception flag from EX
- ecode_EX  in  6  exception code from EX
- data_sram_data_ok  in  1  one response beat valid this cycle
- data_sram_rdata  in  32  response data
- rf_we  out  1  register write enable to WB
- rf_waddr  out  5  destination register to WB
- rf_wdata  out  32  write-back data to WB
- ex  out  1  exception flag to WB
- ecode  out  6  exception code to WB
- PC  out  32  PC of the instruction in MEM
- load_pending  out  1  valid & res_from_mem & response not yet received (for ID hazard logic)
- discard_busy  out  1  discard counter != 0

Behaviour:
- Reset: valid=0, resp_pending=0, buf_valid=0, discard_cnt=0. All registered outputs (rf_we, rf_waddr, ex, ecode, PC, load_op, alu_result) = 0. to_valid=0.
- Latch: on from_valid & to_allowin, capture all *_EX inputs. resp_pending <= mem_req_EX; buf_valid <= 0. valid <= from_valid & ~flush_WB whenever to_allowin.
- data_ok_eff = data_sram_data_ok & (discard_cnt==0). Responses are strictly in order.
- ready_go = ~resp_pending | buf_valid | data_ok_eff.
- to_valid = valid & ready_go & ~flush_WB.
- to_allowin = (~valid | ready_go & from_allowin) & (discard_cnt != MAX_DISCARD).
- Buffering: if valid & resp_pending & data_ok_eff & ~from_allowin, store rdata and set buf_valid=1. Cleared when the instruction leaves or is flushed.
- rf_wdata: res_from_mem ? ext(buf_valid ? buf : data_sram_rdata) : alu_result.
- Extension:
  - byte select by alu_result[1:0]; halfword by alu_result[1].
  - ld.b and ld.h sign-extend; ld.bu and ld.hu zero-extend; ld.w passes through.
- Discard counter, per cycle:
  - inc = flush_WB & valid & resp_pending & ~buf_valid & ~data_ok_eff.
  - dec = data_sram_data_ok & (discard_cnt != 0).
  - inc & dec together: count unchanged.
  - Never wraps; to_allowin low at MAX_DISCARD guarantees no overflow.
- Flush: valid <= 0 next cycle. Any buffered data is dropped. An incoming EX instruction in the same cycle is also killed.
- Reset mid-wait: all state cleared, including discard_cnt. The external SRAM is reset in the same cycle.

Optional Feature:
- MEM_STALL_CNT_EN defined: adds output stall_cnt [PERF_W-1:0].
  - Reset 0.
  - Increments each cycle valid & ~ready_go.
  - Wraps modulo 2**PERF_W.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- ld.w, addr 0x1000, data_ok 3 cycles later, rdata=0x8899AABB -> to_valid rises the same cycle as data_ok; rf_wdata=0x8899AABB; load_pending=1 for 3 cycles.
- ld.b at addr[1:0]=3, rdata=0x80112233 -> rf_wdata=0xFFFFFF80. ld.hu at addr[1:0]=2 -> 0x00008011. ld.h at addr[1:0]=0 -> 0x00002233.
- data_ok arrives while from_allowin=0 for 4 cycles, rdata changes after capture -> rf_wdata holds the captured value; to_valid stays 1 until from_allowin=1.
- flush_WB while a load awaits its response -> discard_cnt=1. The next data_ok (0xDEAD) is dropped and not forwarded; a following load gets its own data correctly.
- Three consecutive flushed pending loads with CNT_W=2 -> discard_cnt=3, to_allowin=0 until one data_ok arrives. Flush coinciding with a discarded data_ok -> count unchanged.
- ALU op (mem_req_EX=0), alu_result=0x1234 -> to_valid the cycle after entry, rf_wdata=0x1234. reset asserted mid-wait -> all outputs 0 next cycle.
